// File: rtl/flappy_game_ctrl.sv
// Game sequencer for the Flappy Bird datapath: IDLE/READY/PLAY/DYING/OVER control,
// flap pulse generation, and BCD score and high-score tracking.
module flappy_game_ctrl #(
   parameter int COUNTDOWN_CYCLES = 100_000_000,
   parameter int DEATH_CYCLES     = 50_000_000,
   parameter int TIMER_W          = 27
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        flap_btn_i,
   input  logic        pipe_collision_i,
   input  logic        pipe_passed_i,
   input  logic        bird_ground_i,
   output logic        pipe_enable_o,
   output logic        pipe_reset_o,
   output logic        bird_enable_o,
   output logic        bird_reset_o,
   output logic        flap_pulse_o,
   output logic [11:0] score_bcd_o,
   output logic [11:0] high_bcd_o,
   output logic [2:0]  game_state_o,
   output logic        game_over_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READY = 3'd1,
      PLAY  = 3'd2,
      DYING = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic [TIMER_W-1:0] CD_LAST    = TIMER_W'(COUNTDOWN_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DEATH_LAST = TIMER_W'(DEATH_CYCLES - 1);

   state_t              state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [11:0]         score_q, score_d;
   logic [11:0]         high_q, high_d;
   logic                btn_q;
   logic                pipe_enable_q, pipe_enable_d;
   logic                pipe_reset_q, pipe_reset_d;
   logic                bird_enable_q, bird_enable_d;
   logic                bird_reset_q, bird_reset_d;
   logic                flap_pulse_q, flap_pulse_d;
   logic                game_over_q, game_over_d;
   logic                rise_s;
   logic                hit_s;
   logic                restart_s;

   // Three-digit BCD increment, saturating at 999.
   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [3:0] d0, d1, d2;
      d0 = v[3:0];
      d1 = v[7:4];
      d2 = v[11:8];
      if (v == 12'h999) begin
         return v;
      end else if (d0 != 4'd9) begin
         d0 = d0 + 4'd1;
      end else if (d1 != 4'd9) begin
         d0 = 4'd0;
         d1 = d1 + 4'd1;
      end else begin
         d0 = 4'd0;
         d1 = 4'd0;
         d2 = d2 + 4'd1;
      end
      return {d2, d1, d0};
   endfunction

   // Valid BCD orders like binary, so a plain compare checks hundreds digit first.
   function automatic logic bcd_gt(input logic [11:0] a, input logic [11:0] b);
      return (a > b);
   endfunction

   assign rise_s    = flap_btn_i & ~btn_q;
   assign hit_s     = pipe_collision_i | bird_ground_i;
   assign restart_s = (state_q == OVER) & rise_s;

   // Next-state, timer and score logic.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      score_d      = score_q;
      high_d       = high_q;
      flap_pulse_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise_s) begin
               state_d = READY;
               timer_d = '0;
               score_d = 12'h000;
            end else begin
               state_d = IDLE;
            end
         end
         READY: begin
            if (timer_q == CD_LAST) begin
               state_d = PLAY;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         PLAY: begin
            if (hit_s) begin
               state_d = DYING;
               timer_d = '0;
            end else begin
               flap_pulse_d = rise_s;
               if (pipe_passed_i) begin
                  score_d = bcd_inc(score_q);
               end else begin
                  score_d = score_q;
               end
            end
         end
         DYING: begin
            if (timer_q == DEATH_LAST) begin
               state_d = OVER;
               timer_d = '0;
               if (bcd_gt(score_q, high_q)) begin
                  high_d = score_q;
               end else begin
                  high_d = high_q;
               end
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         OVER: begin
            if (rise_s) begin
               state_d = READY;
               timer_d = '0;
               score_d = 12'h000;
            end else begin
               state_d = OVER;
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   // Outputs follow the next state; a restart from OVER adds a one-cycle reset pulse.
   always_comb begin
      pipe_enable_d = (state_d == PLAY);
      bird_enable_d = (state_d == PLAY);
      pipe_reset_d  = (state_d == IDLE) | restart_s;
      bird_reset_d  = (state_d == IDLE) | restart_s;
      game_over_d   = (state_d == OVER);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      btn_q <= flap_btn_i;
      if (!reset_n_i) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         score_q       <= 12'h000;
         high_q        <= 12'h000;
         pipe_enable_q <= 1'b0;
         pipe_reset_q  <= 1'b1;
         bird_enable_q <= 1'b0;
         bird_reset_q  <= 1'b1;
         flap_pulse_q  <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         score_q       <= score_d;
         high_q        <= high_d;
         pipe_enable_q <= pipe_enable_d;
         pipe_reset_q  <= pipe_reset_d;
         bird_enable_q <= bird_enable_d;
         bird_reset_q  <= bird_reset_d;
         flap_pulse_q  <= flap_pulse_d;
         game_over_q   <= game_over_d;
      end
   end

   assign pipe_enable_o = pipe_enable_q;
   assign pipe_reset_o  = pipe_reset_q;
   assign bird_enable_o = bird_enable_q;
   assign bird_reset_o  = bird_reset_q;
   assign flap_pulse_o  = flap_pulse_q;
   assign score_bcd_o   = score_q;
   assign high_bcd_o    = high_q;
   assign game_state_o  = state_q;
   assign game_over_o   = game_over_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed self-checking bench for flappy_game_ctrl with a short countdown and death time.
module tb_flappy_game_ctrl;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READY = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_DYING = 3'd3;
   localparam logic [2:0] S_OVER  = 3'd4;

   logic        clk_i = 1'b0;
   logic        reset_n_i = 1'b0;
   logic        flap_btn_i = 1'b0;
   logic        pipe_collision_i = 1'b0;
   logic        pipe_passed_i = 1'b0;
   logic        bird_ground_i = 1'b0;
   logic        pipe_enable_o;
   logic        pipe_reset_o;
   logic        bird_enable_o;
   logic        bird_reset_o;
   logic        flap_pulse_o;
   logic [11:0] score_bcd_o;
   logic [11:0] high_bcd_o;
   logic [2:0]  game_state_o;
   logic        game_over_o;

   int errors = 0;
   int checks = 0;
   int pulses;

   flappy_game_ctrl #(
      .COUNTDOWN_CYCLES(4),
      .DEATH_CYCLES    (3),
      .TIMER_W         (27)
   ) dut (
      .clk_i           (clk_i),
      .reset_n_i       (reset_n_i),
      .flap_btn_i      (flap_btn_i),
      .pipe_collision_i(pipe_collision_i),
      .pipe_passed_i   (pipe_passed_i),
      .bird_ground_i   (bird_ground_i),
      .pipe_enable_o   (pipe_enable_o),
      .pipe_reset_o    (pipe_reset_o),
      .bird_enable_o   (bird_enable_o),
      .bird_reset_o    (bird_reset_o),
      .flap_pulse_o    (flap_pulse_o),
      .score_bcd_o     (score_bcd_o),
      .high_bcd_o      (high_bcd_o),
      .game_state_o    (game_state_o),
      .game_over_o     (game_over_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
      int n;
      n = 0;
      while (game_state_o !== tgt && n < budget) begin
         step();
         n++;
      end
      check_eq(tag, {9'd0, game_state_o}, {9'd0, tgt});
   endtask

   task automatic press();
      flap_btn_i = 1'b1;
      step();
      flap_btn_i = 1'b0;
   endtask

   task automatic score_pipes(input int n);
      pipe_passed_i = 1'b1;
      repeat (n) step();
      pipe_passed_i = 1'b0;
   endtask

   task automatic die_by_ground();
      bird_ground_i = 1'b1;
      step();
      bird_ground_i = 1'b0;
   endtask

   initial begin
      repeat (3) step();
      check_eq("rst_state", {9'd0, game_state_o}, {9'd0, S_IDLE});
      check_eq("rst_pipe_reset", {11'd0, pipe_reset_o}, 12'd1);
      check_eq("rst_bird_reset", {11'd0, bird_reset_o}, 12'd1);
      check_eq("rst_enable", {10'd0, pipe_enable_o, bird_enable_o}, 12'd0);
      check_eq("rst_score", score_bcd_o, 12'h000);
      check_eq("rst_high", high_bcd_o, 12'h000);
      reset_n_i = 1'b1;
      step();
      check_eq("idle_hold", {9'd0, game_state_o}, {9'd0, S_IDLE});

      // Game 1: exact countdown timing, flap edge detection, score and collision priority.
      press();
      check_eq("idle_to_ready", {9'd0, game_state_o}, {9'd0, S_READY});
      check_eq("ready_pipe_reset", {11'd0, pipe_reset_o}, 12'd0);
      step(); step(); step();
      check_eq("ready_still", {9'd0, game_state_o}, {9'd0, S_READY});
      step();
      check_eq("ready_to_play", {9'd0, game_state_o}, {9'd0, S_PLAY});
      check_eq("play_pipe_en", {11'd0, pipe_enable_o}, 12'd1);
      check_eq("play_bird_en", {11'd0, bird_enable_o}, 12'd1);
      check_eq("play_pipe_rst", {11'd0, pipe_reset_o}, 12'd0);

      pulses = 0;
      flap_btn_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         pulses += int'(flap_pulse_o);
      end
      flap_btn_i = 1'b0;
      step();
      pulses += int'(flap_pulse_o);
      check_eq("flap_once", pulses[11:0], 12'd1);

      score_pipes(12);
      check_eq("score_12", score_bcd_o, 12'h012);
      pipe_passed_i    = 1'b1;
      pipe_collision_i = 1'b1;
      flap_btn_i       = 1'b1;
      step();
      pipe_passed_i    = 1'b0;
      pipe_collision_i = 1'b0;
      check_eq("hit_to_dying", {9'd0, game_state_o}, {9'd0, S_DYING});
      check_eq("hit_no_inc", score_bcd_o, 12'h012);
      check_eq("hit_no_flap", {11'd0, flap_pulse_o}, 12'd0);
      check_eq("dying_en", {10'd0, pipe_enable_o, bird_enable_o}, 12'd0);
      check_eq("dying_no_rst", {11'd0, pipe_reset_o}, 12'd0);
      flap_btn_i = 1'b0;
      step();
      flap_btn_i = 1'b1;
      check_eq("dying_still", {9'd0, game_state_o}, {9'd0, S_DYING});
      step();
      flap_btn_i = 1'b0;
      check_eq("dying_btn_ignored", {9'd0, game_state_o}, {9'd0, S_DYING});
      check_eq("dying_btn_no_flap", {11'd0, flap_pulse_o}, 12'd0);
      step();
      check_eq("dying_to_over", {9'd0, game_state_o}, {9'd0, S_OVER});
      check_eq("over_flag", {11'd0, game_over_o}, 12'd1);
      check_eq("high_12", high_bcd_o, 12'h012);
      step();
      check_eq("over_score_hold", score_bcd_o, 12'h012);

      // Game 2: restart pulse, ignored button in READY, lower score keeps the high.
      press();
      check_eq("restart_ready", {9'd0, game_state_o}, {9'd0, S_READY});
      check_eq("restart_pipe_rst", {11'd0, pipe_reset_o}, 12'd1);
      check_eq("restart_bird_rst", {11'd0, bird_reset_o}, 12'd1);
      check_eq("restart_score0", score_bcd_o, 12'h000);
      check_eq("restart_over_clr", {11'd0, game_over_o}, 12'd0);
      flap_btn_i = 1'b1;
      step();
      flap_btn_i = 1'b0;
      check_eq("pulse_end_pipe_rst", {11'd0, pipe_reset_o}, 12'd0);
      check_eq("pulse_end_bird_rst", {11'd0, bird_reset_o}, 12'd0);
      check_eq("ready_btn_ignored", {9'd0, game_state_o}, {9'd0, S_READY});
      check_eq("ready_btn_no_flap", {11'd0, flap_pulse_o}, 12'd0);
      wait_state(S_PLAY, 10, "g2_play");
      score_pipes(5);
      check_eq("score_5", score_bcd_o, 12'h005);
      die_by_ground();
      check_eq("ground_dying", {9'd0, game_state_o}, {9'd0, S_DYING});
      wait_state(S_OVER, 10, "g2_over");
      check_eq("high_keep_12", high_bcd_o, 12'h012);

      // Game 3: new best score.
      step();
      press();
      wait_state(S_PLAY, 10, "g3_play");
      score_pipes(13);
      die_by_ground();
      wait_state(S_OVER, 10, "g3_over");
      check_eq("score_13", score_bcd_o, 12'h013);
      check_eq("high_13", high_bcd_o, 12'h013);

      // Game 4: carries, saturation, then reset mid-play clears everything.
      step();
      press();
      wait_state(S_PLAY, 10, "g4_play");
      score_pipes(100);
      check_eq("score_100", score_bcd_o, 12'h100);
      score_pipes(899);
      check_eq("score_999", score_bcd_o, 12'h999);
      score_pipes(1);
      check_eq("score_sat", score_bcd_o, 12'h999);
      reset_n_i = 1'b0;
      step();
      check_eq("midrst_state", {9'd0, game_state_o}, {9'd0, S_IDLE});
      check_eq("midrst_pipe_rst", {11'd0, pipe_reset_o}, 12'd1);
      check_eq("midrst_score", score_bcd_o, 12'h000);
      check_eq("midrst_high", high_bcd_o, 12'h000);
      check_eq("midrst_en", {10'd0, pipe_enable_o, bird_enable_o}, 12'd0);

      // Button held across reset release must not start a game.
      flap_btn_i = 1'b1;
      step();
      reset_n_i = 1'b1;
      step();
      step();
      check_eq("held_btn_no_start", {9'd0, game_state_o}, {9'd0, S_IDLE});
      flap_btn_i = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
